// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: ALU reservation station with CDB wakeup and single-issue select to EX
// Build option ALU_RS_AGE_SELECT_EN selects oldest-first issue instead of lowest-index priority.
module alu_issue_scheduler #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_in,
  input  logic              dispatch_in,
  input  logic [DATA_W-1:0] rs1_val_in,
  input  logic [ROB_W-1:0]  rs1_tag_in,
  input  logic              rs1_rdy_in,
  input  logic [DATA_W-1:0] rs2_val_in,
  input  logic [ROB_W-1:0]  rs2_tag_in,
  input  logic              rs2_rdy_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] inst_addr_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [6:0]        funct7_in,
  input  logic [ROB_W-1:0]  rob_pos_in,
  output logic              full_out,
  input  logic              cdb_valid_in,
  input  logic [ROB_W-1:0]  cdb_rob_pos_in,
  input  logic [DATA_W-1:0] cdb_data_in,
  output logic              transmit_to_ex,
  output logic [DATA_W-1:0] rs1_to_ex,
  output logic [DATA_W-1:0] rs2_to_ex,
  output logic [DATA_W-1:0] imm_to_ex,
  output logic [DATA_W-1:0] inst_addr_to_ex,
  output logic [6:0]        opcode_to_ex,
  output logic [2:0]        funct3_to_ex,
  output logic [6:0]        funct7_to_ex,
  output logic [ROB_W-1:0]  rob_pos_to_ex
);
  logic [DEPTH-1:0]  r_busy, r_q1, r_q2;
  logic [DATA_W-1:0] r_v1 [DEPTH];
  logic [DATA_W-1:0] r_v2 [DEPTH];
  logic [DATA_W-1:0] r_imm [DEPTH];
  logic [DATA_W-1:0] r_addr [DEPTH];
  logic [ROB_W-1:0]  r_t1 [DEPTH];
  logic [ROB_W-1:0]  r_t2 [DEPTH];
  logic [ROB_W-1:0]  r_rob [DEPTH];
  logic [6:0]        r_op [DEPTH];
  logic [2:0]        r_f3 [DEPTH];
  logic [6:0]        r_f7 [DEPTH];
  logic [DEPTH-1:0]  w_ready;
  logic [IDX_W-1:0]  w_sel, w_free;
  logic              w_has, w_byp1, w_byp2, w_disp;
  assign w_ready  = r_busy & r_q1 & r_q2;
  assign w_has    = |w_ready;
  assign full_out = &r_busy;
  assign w_disp   = dispatch_in && !full_out;
  assign w_byp1   = !rs1_rdy_in && cdb_valid_in && cdb_rob_pos_in == rs1_tag_in;
  assign w_byp2   = !rs2_rdy_in && cdb_valid_in && cdb_rob_pos_in == rs2_tag_in;
  always_comb begin
    w_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--) w_free = r_busy[i] ? w_free : IDX_W'(i);
  end
`ifdef ALU_RS_AGE_SELECT_EN
  logic [IDX_W:0] r_age [DEPTH];
  logic [IDX_W:0] w_cnt, w_best;
  always_comb begin
    w_sel  = '0;
    w_best = '1;
    w_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + (IDX_W+1)'(r_busy[i]);
      if (w_ready[i] && r_age[i] < w_best) begin
        w_best = r_age[i];
        w_sel  = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) w_sel = w_ready[i] ? IDX_W'(i) : w_sel;
  end
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy          <= '0;
      r_q1            <= '0;
      r_q2            <= '0;
      transmit_to_ex  <= 1'b0;
      rs1_to_ex       <= '0;
      rs2_to_ex       <= '0;
      imm_to_ex       <= '0;
      inst_addr_to_ex <= '0;
      opcode_to_ex    <= '0;
      funct3_to_ex    <= '0;
      funct7_to_ex    <= '0;
      rob_pos_to_ex   <= '0;
    end else if (clear_in) begin
      r_busy         <= '0;
      transmit_to_ex <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid_in && r_busy[i] && !r_q1[i] && r_t1[i] == cdb_rob_pos_in) begin
          r_q1[i] <= 1'b1;
          r_v1[i] <= cdb_data_in;
        end
        if (cdb_valid_in && r_busy[i] && !r_q2[i] && r_t2[i] == cdb_rob_pos_in) begin
          r_q2[i] <= 1'b1;
          r_v2[i] <= cdb_data_in;
        end
`ifdef ALU_RS_AGE_SELECT_EN
        if (w_has && r_busy[i] && r_age[i] > r_age[w_sel]) r_age[i] <= r_age[i] - 1'b1;
`endif
      end
      transmit_to_ex <= w_has;
      if (w_has) begin
        r_busy[w_sel]   <= 1'b0;
        rs1_to_ex       <= r_v1[w_sel];
        rs2_to_ex       <= r_v2[w_sel];
        imm_to_ex       <= r_imm[w_sel];
        inst_addr_to_ex <= r_addr[w_sel];
        opcode_to_ex    <= r_op[w_sel];
        funct3_to_ex    <= r_f3[w_sel];
        funct7_to_ex    <= r_f7[w_sel];
        rob_pos_to_ex   <= r_rob[w_sel];
      end
      // free index comes from pre-edge state, so a slot freed by this issue is never reused here
      if (w_disp) begin
        r_busy[w_free] <= 1'b1;
        r_q1[w_free]   <= rs1_rdy_in | w_byp1;
        r_q2[w_free]   <= rs2_rdy_in | w_byp2;
        r_v1[w_free]   <= rs1_rdy_in ? rs1_val_in : cdb_data_in;
        r_v2[w_free]   <= rs2_rdy_in ? rs2_val_in : cdb_data_in;
        r_t1[w_free]   <= rs1_tag_in;
        r_t2[w_free]   <= rs2_tag_in;
        r_imm[w_free]  <= imm_in;
        r_addr[w_free] <= inst_addr_in;
        r_op[w_free]   <= opcode_in;
        r_f3[w_free]   <= funct3_in;
        r_f7[w_free]   <= funct7_in;
        r_rob[w_free]  <= rob_pos_in;
`ifdef ALU_RS_AGE_SELECT_EN
        r_age[w_free]  <= w_cnt - (IDX_W+1)'(w_has);
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb_alu_issue_scheduler: table-driven and directed checks of the ALU reservation station
module tb_alu_issue_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, clear_in, dispatch_in, rs1_rdy_in, rs2_rdy_in, cdb_valid_in;
  logic [31:0] rs1_val_in, rs2_val_in, imm_in, inst_addr_in, cdb_data_in;
  logic [3:0]  rs1_tag_in, rs2_tag_in, rob_pos_in, cdb_rob_pos_in;
  logic [6:0]  opcode_in, funct7_in;
  logic [2:0]  funct3_in;
  logic        full_out, transmit_to_ex;
  logic [31:0] rs1_to_ex, rs2_to_ex, imm_to_ex, inst_addr_to_ex;
  logic [6:0]  opcode_to_ex, funct7_to_ex;
  logic [2:0]  funct3_to_ex;
  logic [3:0]  rob_pos_to_ex;
  int checks = 0, errors = 0;
`ifdef ALU_RS_AGE_SELECT_EN
  localparam int FIRST = 5, SECOND = 12;
`else
  localparam int FIRST = 12, SECOND = 5;
`endif
  alu_issue_scheduler dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear_in), .dispatch_in(dispatch_in),
    .rs1_val_in(rs1_val_in), .rs1_tag_in(rs1_tag_in), .rs1_rdy_in(rs1_rdy_in),
    .rs2_val_in(rs2_val_in), .rs2_tag_in(rs2_tag_in), .rs2_rdy_in(rs2_rdy_in),
    .imm_in(imm_in), .inst_addr_in(inst_addr_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .funct7_in(funct7_in), .rob_pos_in(rob_pos_in),
    .full_out(full_out), .cdb_valid_in(cdb_valid_in), .cdb_rob_pos_in(cdb_rob_pos_in),
    .cdb_data_in(cdb_data_in), .transmit_to_ex(transmit_to_ex), .rs1_to_ex(rs1_to_ex),
    .rs2_to_ex(rs2_to_ex), .imm_to_ex(imm_to_ex), .inst_addr_to_ex(inst_addr_to_ex),
    .opcode_to_ex(opcode_to_ex), .funct3_to_ex(funct3_to_ex), .funct7_to_ex(funct7_to_ex),
    .rob_pos_to_ex(rob_pos_to_ex)
  );
  typedef struct {
    int d, r1r, r1v, r1t, r2r, r2v, r2t, imm, rob, cv, ct, cd, clr;
    int ef, et, er1, er2, eimm, erob;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
    end
  endtask
  task automatic drive(input int d, r1r, r1v, r1t, r2r, r2v, r2t, imm, rob, cv, ct, cd, clr);
    dispatch_in    = d[0];
    rs1_rdy_in     = r1r[0];
    rs1_val_in     = r1v;
    rs1_tag_in     = 4'(r1t);
    rs2_rdy_in     = r2r[0];
    rs2_val_in     = r2v;
    rs2_tag_in     = 4'(r2t);
    imm_in         = imm;
    rob_pos_in     = 4'(rob);
    inst_addr_in   = 32'h1000 + 32'(rob * 4);
    opcode_in      = 7'(8'h10 + rob);
    funct3_in      = 3'(rob);
    funct7_in      = 7'(rob);
    cdb_valid_in   = cv[0];
    cdb_rob_pos_in = 4'(ct);
    cdb_data_in    = cd;
    clear_in       = clr[0];
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_issue(input string n, input int rob, input int r1, input int r2, input int imm);
    chk({n, ".tx"}, int'(transmit_to_ex), 1);
    chk({n, ".rob"}, int'(rob_pos_to_ex), rob);
    chk({n, ".rs1"}, int'(rs1_to_ex), r1);
    chk({n, ".rs2"}, int'(rs2_to_ex), r2);
    chk({n, ".imm"}, int'(imm_to_ex), imm);
    chk({n, ".addr"}, int'(inst_addr_to_ex), 32'h1000 + rob * 4);
    chk({n, ".op"}, int'(opcode_to_ex), 'h10 + rob);
    chk({n, ".f3"}, int'(funct3_to_ex), rob & 7);
    chk({n, ".f7"}, int'(funct7_to_ex), rob);
  endtask
  initial begin
    //               d r1r  r1v r1t r2r r2v r2t imm rob cv ct  cd clr ef et er1 er2 eimm erob
    vecs.push_back('{1, 1,    5, 0, 1,    0, 0, 7, 3,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 1,    5,    0, 7, 3});
    vecs.push_back('{1, 0,    0, 2, 1,    1, 0, 0, 4,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  1, 3, 'h99, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  1, 2, 'h10, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 1, 'h10,    1, 0, 4});
    vecs.push_back('{1, 1,    2, 0, 0,    0, 6, 0, 5,  1, 6, 'hAB, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 1,    2, 'hAB, 0, 5});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1, 0, 0, 12 + k, 1, 0, 0, 0, 8 + k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 'h11, 0, 1, 'h11, 0, 0, 1,  1, 12,   1, 1, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  1, 13,   2, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{1, 1, 'h22, 0, 1, 'h33, 0, 9, 2,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 1, 'h22, 'h33, 9, 2});
    vecs.push_back('{1, 1, 'h66, 0, 1,    0, 0, 0, 6,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    vecs.push_back('{1, 1, 'h77, 0, 1,    0, 0, 1, 7,  0, 0,    0, 0, 0, 1, 'h66,    0, 0, 6});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 1, 'h77,    0, 1, 7});
    vecs.push_back('{0, 0,    0, 0, 0,    0, 0, 0, 0,  0, 0,    0, 0, 0, 0,    0,    0, 0, 0});
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("reset.tx", int'(transmit_to_ex), 0);
    chk("reset.full", int'(full_out), 0);
    chk("reset.rs1", int'(rs1_to_ex), 0);
    chk("reset.rs2", int'(rs2_to_ex), 0);
    chk("reset.imm", int'(imm_to_ex), 0);
    chk("reset.addr", int'(inst_addr_to_ex), 0);
    chk("reset.op", int'(opcode_to_ex), 0);
    chk("reset.rob", int'(rob_pos_to_ex), 0);
    foreach (vecs[k]) begin
      drive(vecs[k].d, vecs[k].r1r, vecs[k].r1v, vecs[k].r1t, vecs[k].r2r, vecs[k].r2v,
            vecs[k].r2t, vecs[k].imm, vecs[k].rob, vecs[k].cv, vecs[k].ct, vecs[k].cd, vecs[k].clr);
      chk($sformatf("vec%0d.full", k), int'(full_out), vecs[k].ef);
      tick();
      chk($sformatf("vec%0d.tx", k), int'(transmit_to_ex), vecs[k].et);
      if (vecs[k].et != 0)
        chk_issue($sformatf("vec%0d", k), vecs[k].erob, vecs[k].er1, vecs[k].er2, vecs[k].eimm);
    end
    // fill all eight slots with ops waiting on tags 8..15
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8 + i, 1, 0, 0, 0, i, 0, 0, 0, 0);
      chk("t4.notfull", int'(full_out), 0);
      tick();
      chk("t4.noissue", int'(transmit_to_ex), 0);
    end
    chk("t4.full", int'(full_out), 1);
    drive(1, 1, 'hF, 0, 1, 'hF, 0, 0, 15, 0, 0, 0, 0);
    tick();
    chk("t4.drop_tx0", int'(transmit_to_ex), 0);
    idle();
    tick();
    chk("t4.drop_tx1", int'(transmit_to_ex), 0);
    chk("t4.still_full", int'(full_out), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 'h3C, 0);
    tick();
    chk("t4.wake_tx", int'(transmit_to_ex), 0);
    chk("t4.full_pre", int'(full_out), 1);
    idle();
    tick();
    chk_issue("t4", 3, 'h3C, 0, 0);
    chk("t4.full_post", int'(full_out), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t4.clear_full", int'(full_out), 0);
    // entry 5 is dispatched before the op that later refills entry 1
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 8 + i, 1, 0, 0, 0, i, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h9, 0);
    tick();
    chk("t5.wake_tx", int'(transmit_to_ex), 0);
    idle();
    tick();
    chk_issue("t5.e1", 1, 'h9, 0, 0);
    drive(1, 0, 0, 13, 1, 0, 0, 0, 12, 0, 0, 0, 0);
    tick();
    chk("t5.refill_tx", int'(transmit_to_ex), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 'h55, 0);
    tick();
    chk("t5.both_wake_tx", int'(transmit_to_ex), 0);
    idle();
    tick();
    chk_issue("t5.first", FIRST, 'h55, 0, 0);
    tick();
    chk_issue("t5.second", SECOND, 'h55, 0, 0);
    tick();
    chk("t5.drain", int'(transmit_to_ex), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
